// File: rtl/ob_drain_streamer.sv
// Streams a window of output-buffer rows over valid/ready after the matrix multiplier finishes.
// A 2-entry skid buffer absorbs the 1-cycle read latency so reads and transfers overlap at full rate.
module ob_drain_streamer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned COL    = 4,
    parameter int unsigned O_SIZE = 256,
    parameter int unsigned AW     = $clog2(O_SIZE)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [AW:0]          count_i,
    output logic                 mem_cenb_o,
    output logic                 mem_wenb_o,
    output logic [AW-1:0]        mem_addr_o,
    input  logic [COL*WIDTH-1:0] mem_q_i,
    output logic [COL*WIDTH-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned DW = COL * WIDTH;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   sent;
    logic            inflight;
    logic [1:0]      occ;
    logic [DW-1:0]   fifo_q [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            busy_q;
    logic            done_q;

    logic            pop_c;
    logic            issue_c;
    logic [1:0]      occ_nxt_c;
    logic [AW-1:0]   rd_addr_c;

    // occ_nxt_c is the occupancy after this edge's capture and pop; issuing
    // only when it is below 2 guarantees the capture one cycle later fits.
    assign pop_c     = (occ != 2'd0) && out_ready_i;
    assign occ_nxt_c = occ + 2'(inflight) - 2'(pop_c);
    assign rd_addr_c = base_q + issued[AW-1:0];
    assign issue_c   = (state == ST_RUN) && (issued < count_q) && (occ_nxt_c < 2'd2);

    assign mem_cenb_o  = ~issue_c;
    assign mem_wenb_o  = 1'b1;
    assign mem_addr_o  = issue_c ? rd_addr_c : addr_q;

    assign out_valid_o = (occ != 2'd0);
    assign out_data_o  = fifo_q[rd_ptr];
    assign out_last_o  = out_valid_o && (sent == count_q - CW'(1));
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    // Control FSM, read/transfer counters and skid buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= issue_c;
            occ      <= occ_nxt_c;

            if (issue_c) begin
                addr_q <= rd_addr_c;
                issued <= issued + CW'(1);
            end

            if (inflight) begin
                fifo_q[wr_ptr] <= mem_q_i;
                wr_ptr         <= ~wr_ptr;
            end

            if (pop_c) begin
                rd_ptr <= ~rd_ptr;
                sent   <= sent + CW'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q  <= base_addr_i;
                        count_q <= count_i;
                        issued  <= '0;
                        sent    <= '0;
                        busy_q  <= 1'b1;
                        if (count_i == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_c && (issued + CW'(1) == count_q)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_c && (sent + CW'(1) == count_q)) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ob_drain_streamer.sv
// Scoreboard bench for ob_drain_streamer: a behavioural output buffer feeds the DUT and
// expected rows are queued at start and checked as each transfer happens.
module tb_ob_drain_streamer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned COL    = 4;
    localparam int unsigned O_SIZE = 256;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = COL * WIDTH;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   count_i = '0;
    logic          mem_cenb_o;
    logic          mem_wenb_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_q_i = '0;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk = ~clk;

    ob_drain_streamer #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .mem_cenb_o  (mem_cenb_o),
        .mem_wenb_o  (mem_wenb_o),
        .mem_addr_o  (mem_addr_o),
        .mem_q_i     (mem_q_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Output-buffer model: 1-cycle read latency.
    logic [DW-1:0] mem [O_SIZE];
    initial begin
        for (int r = 0; r < O_SIZE; r++) mem[r] = 32'h03020100 + 32'(r) * 32'h04040404;
    end
    always @(posedge clk) if (!mem_cenb_o) mem_q_i <= mem[mem_addr_o];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push_window(input int base, input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.data = mem[(base + i) % O_SIZE];
            e.last = (i == count - 1);
            exp_q.push_back(e);
        end
    endtask

    // Transfer monitor: scoreboard pop, read-ahead bound, stall stability.
    int            iss_cnt = 0;
    int            xfer_cnt = 0;
    int            outstanding;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    exp_t          got;
    always @(negedge clk) begin
        if (rst_i) begin
            iss_cnt    = 0;
            xfer_cnt   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (out_valid_o !== 1'b1 || out_data_o !== prev_data || out_last_o !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             out_valid_o, out_data_o, out_last_o, prev_data, prev_last);
                end
            end
            if (mem_cenb_o === 1'b0) begin
                outstanding = iss_cnt - xfer_cnt - ((out_valid_o && out_ready_i) ? 1 : 0) + 1;
                vectors++;
                if (outstanding > 2) begin
                    miscompares++;
                    $display("FAIL read_ahead: %0d rows pending with this read, required at most 2", outstanding);
                end
                iss_cnt++;
            end
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_row: got data=%h, required no transfer", out_data_o);
                end else begin
                    got = exp_q.pop_front();
                    if (out_data_o !== got.data || out_last_o !== got.last) begin
                        miscompares++;
                        $display("FAIL row: got data=%h last=%b, required data=%h last=%b",
                                 out_data_o, out_last_o, got.data, got.last);
                    end
                end
                xfer_cnt++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
        end
    end

    task automatic launch(input int base, input int count);
        @(posedge clk); #1;
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        count_i     = (AW + 1)'(count);
        push_window(base, count);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mem_cenb_o, mem_wenb_o, out_valid_o, out_last_o, busy_o, done_o} !== 6'b110000
            || mem_addr_o !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: cenb=%b wenb=%b addr=%0d valid=%b last=%b busy=%b done=%b, required 1 1 0 0 0 0 0",
                     mem_cenb_o, mem_wenb_o, mem_addr_o, out_valid_o, out_last_o, busy_o, done_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        int  first_valid = -1, busy_cyc = 0, done_n = 0, done_cyc = -1, last_xfer = -1, xfer_n = 0;
        bit  consec = 1'b1;
        out_ready_i = 1'b1;
        launch(0, 4);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (busy_o) busy_cyc++;
            if (done_o) begin done_n++; done_cyc = c; end
            if (out_valid_o && first_valid < 0) first_valid = c;
            if (out_valid_o && out_ready_i) begin
                if (xfer_n > 0 && c != last_xfer + 1) consec = 1'b0;
                last_xfer = c;
                xfer_n++;
            end
        end
        vectors++;
        if (first_valid != 2) begin miscompares++; $display("FAIL basic_latency: valid in cycle %0d, required 2", first_valid); end
        vectors++;
        if (xfer_n != 4 || !consec) begin miscompares++; $display("FAIL basic_xfers: %0d transfers consec=%0d, required 4 consec=1", xfer_n, consec); end
        vectors++;
        if (done_n != 1 || done_cyc != last_xfer + 1) begin
            miscompares++; $display("FAIL basic_done: %0d pulses at cycle %0d, required 1 at %0d", done_n, done_cyc, last_xfer + 1);
        end
        vectors++;
        if (busy_cyc != 7) begin miscompares++; $display("FAIL basic_busy: %0d cycles, required 7", busy_cyc); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_left: %0d rows unsent, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int xfer_n = 0;
        bit done_seen = 1'b0;
        launch(16, 8);
        for (int c = 0; c < 200 && !done_seen; c++) begin
            @(posedge clk); #1;
            start_i     = 1'b0;
            out_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid_o && out_ready_i) xfer_n++;
            if (done_o) done_seen = 1'b1;
        end
        out_ready_i = 1'b1;
        vectors++;
        if (!done_seen || xfer_n != 8 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_window: done=%0d transfers=%0d left=%0d, required 1 8 0", done_seen, xfer_n, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4];
        logic [AW-1:0] got_addr [4];
        int            n = 0;
        bit            done_seen = 1'b0;
        exp_addr[0] = 8'd254; exp_addr[1] = 8'd255; exp_addr[2] = 8'd0; exp_addr[3] = 8'd1;
        out_ready_i = 1'b1;
        launch(254, 4);
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (!mem_cenb_o) begin
                if (n < 4) got_addr[n] = mem_addr_o;
                n++;
            end
            if (done_o) done_seen = 1'b1;
        end
        vectors++;
        if (n != 4 || !done_seen) begin miscompares++; $display("FAIL wrap_reads: %0d reads done=%0d, required 4 1", n, done_seen); end
        for (int i = 0; i < 4 && i < n; i++) begin
            vectors++;
            if (got_addr[i] !== exp_addr[i]) begin
                miscompares++; $display("FAIL wrap_addr%0d: got %0d, required %0d", i, got_addr[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_zero();
        int done_n = 0, done_cyc = -1, valid_n = 0, rd_n = 0;
        launch(3, 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (done_o) begin done_n++; done_cyc = c; end
            if (out_valid_o) valid_n++;
            if (!mem_cenb_o) rd_n++;
        end
        vectors++;
        if (done_n != 1 || done_cyc != 0) begin miscompares++; $display("FAIL zero_done: %0d pulses at cycle %0d, required 1 at 0", done_n, done_cyc); end
        vectors++;
        if (valid_n != 0 || rd_n != 0) begin miscompares++; $display("FAIL zero_quiet: valid %0d reads %0d, required 0 0", valid_n, rd_n); end
    endtask

    task automatic test_full();
        int  xfer_n = 0, last_n = 0;
        bit  done_seen = 1'b0;
        out_ready_i = 1'b1;
        launch(5, 256);
        for (int c = 0; c < 400 && !done_seen; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (out_valid_o && out_ready_i) begin
                xfer_n++;
                if (out_last_o) last_n++;
            end
            if (done_o) done_seen = 1'b1;
        end
        vectors++;
        if (!done_seen || xfer_n != 256 || last_n != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_window: done=%0d transfers=%0d lasts=%0d left=%0d, required 1 256 1 0",
                     done_seen, xfer_n, last_n, exp_q.size());
        end
    endtask

    task automatic test_start_busy();
        int xfer_n = 0, done_n = 0, post_valid = 0;
        out_ready_i = 1'b1;
        launch(40, 8);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (c == 3) begin
                start_i     = 1'b1;
                base_addr_i = 8'd100;
                count_i     = 9'd2;
            end
            @(negedge clk);
            if (out_valid_o && out_ready_i) xfer_n++;
            if (done_o) done_n++;
            if (done_n > 0 && !done_o && out_valid_o) post_valid++;
        end
        vectors++;
        if (xfer_n != 8 || done_n != 1 || post_valid != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL start_busy: transfers=%0d done=%0d late_valid=%0d left=%0d, required 8 1 0 0",
                     xfer_n, done_n, post_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, xfer_n = 0;
        bit done_seen = 1'b0;
        out_ready_i = 1'b1;
        launch(0, 8);
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (out_valid_o && out_ready_i) n++;
        end
        @(posedge clk); #1;
        rst_i       = 1'b1;
        out_ready_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        vectors++;
        if (n != 3 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || mem_cenb_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: seen=%0d valid=%b busy=%b cenb=%b, required 3 0 0 1", n, out_valid_o, busy_o, mem_cenb_o);
        end
        out_ready_i = 1'b1;
        launch(0, 2);
        for (int c = 0; c < 30 && !done_seen; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (out_valid_o && out_ready_i) xfer_n++;
            if (done_o) done_seen = 1'b1;
        end
        vectors++;
        if (!done_seen || xfer_n != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL restart: done=%0d transfers=%0d left=%0d, required 1 2 0", done_seen, xfer_n, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_full();
        test_start_busy();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
